// File: rtl/sga_body_shift_ctrl.sv
// Snake body RAM sequencer for one game step: computes the new head, flags wall/self/apple
// hits, shifts every segment one slot toward the tail and writes the new head at address 0.
module sga_body_shift_ctrl #(
    parameter int unsigned      POS_W    = 4,
    parameter int unsigned      MAX_LEN  = 16,
    parameter int unsigned      LEN_W    = 5,
    parameter logic [POS_W-1:0] INIT_POS = POS_W'(5)
) (
    input  logic               clock,
    input  logic               restart_n,
    input  logic               clear,
    input  logic               move_req,
    input  logic [1:0]         direction,
    input  logic [POS_W-1:0]   apple_pos,
    input  logic [POS_W-1:0]   ram_rdata,
    output logic [LEN_W-2:0]   ram_addr,
    output logic [POS_W-1:0]   ram_wdata,
    output logic               ram_we,
    output logic               busy,
    output logic               done,
    output logic               ate_apple,
    output logic               wall_collision,
    output logic               self_collision,
    output logic               win,
    output logic [POS_W-1:0]   head_pos,
    output logic [LEN_W-1:0]   length
);

    localparam int unsigned HALF   = POS_W / 2;
    localparam int unsigned ADDR_W = LEN_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CALC,
        S_RD,
        S_WR,
        S_HEAD,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_idx;
    logic [POS_W-1:0]    r_new_head;
    logic                r_eat;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_we;
    logic                r_busy;
    logic                r_done;
    logic                r_ate;
    logic                r_wall;
    logic                r_self;
    logic                r_win;
    logic [POS_W-1:0]    r_head;
    logic [LEN_W-1:0]    r_len;

    state_t              w_next_state;
    logic [LEN_W-1:0]    w_next_idx;
    logic [ADDR_W-1:0]   w_ram_addr_nx;
    logic                w_ram_we_nx;
    logic [HALF-1:0]     w_x;
    logic [POS_W-HALF-1:0] w_y;
    logic [HALF-1:0]     w_nx;
    logic [POS_W-HALF-1:0] w_ny;
    logic                w_wall_hit;
    logic [POS_W-1:0]    w_step_head;
    logic                w_self_hit;
    logic [LEN_W-1:0]    w_grow_len;
    logic [LEN_W-1:0]    w_new_len;

    assign w_x         = r_head[HALF-1:0];
    assign w_y         = r_head[POS_W-1:HALF];
    assign w_step_head = {w_ny, w_nx};
    assign w_grow_len  = r_len + LEN_W'(1);
    assign w_new_len   = r_eat ? w_grow_len : r_len;
    // The tail cell only counts as occupied when the snake grows this step.
    assign w_self_hit  = (r_state == S_WR) && (ram_rdata == r_new_head) &&
                         ((r_idx != (r_len - LEN_W'(1))) || r_eat);

    // Candidate head and wall detection from the current head and direction.
    always_comb begin
        w_nx       = w_x;
        w_ny       = w_y;
        w_wall_hit = 1'b0;
        case (direction)
            2'b00: begin
                w_wall_hit = (w_x == '0);
                w_nx       = w_x - HALF'(1);
            end
            2'b01: begin
                w_wall_hit = (w_x == {HALF{1'b1}});
                w_nx       = w_x + HALF'(1);
            end
            2'b10: begin
                w_wall_hit = (w_y == '0);
                w_ny       = w_y - (POS_W-HALF)'(1);
            end
            2'b11: begin
                w_wall_hit = (w_y == {(POS_W-HALF){1'b1}});
                w_ny       = w_y + (POS_W-HALF)'(1);
            end
            default: ;
        endcase
    end

    // Next state, segment index and the RAM controls for the upcoming state.
    always_comb begin
        w_next_state  = r_state;
        w_next_idx    = r_idx;
        w_ram_addr_nx = '0;
        w_ram_we_nx   = 1'b0;
        case (r_state)
            S_IDLE: if (move_req && !(r_wall || r_self || r_win)) w_next_state = S_CALC;
            S_CALC: begin
                if (w_wall_hit) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RD;
                    w_next_idx   = r_len - LEN_W'(1);
                end
            end
            S_RD:   w_next_state = S_WR;
            S_WR: begin
                if (r_idx == '0) begin
                    w_next_state = S_HEAD;
                end else begin
                    w_next_state = S_RD;
                    w_next_idx   = r_idx - LEN_W'(1);
                end
            end
            S_HEAD: w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            S_INIT: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (clear) w_next_state = S_INIT;

        case (w_next_state)
            S_INIT: w_ram_we_nx = 1'b1;
            S_RD:   w_ram_addr_nx = ADDR_W'(w_next_idx);
            S_WR: begin
                w_ram_we_nx   = 1'b1;
                w_ram_addr_nx = ADDR_W'(w_next_idx + LEN_W'(1));
            end
            S_HEAD: w_ram_we_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_new_head <= '0;
            r_eat      <= 1'b0;
            r_ram_addr <= '0;
            r_ram_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ate      <= 1'b0;
            r_wall     <= 1'b0;
            r_self     <= 1'b0;
            r_win      <= 1'b0;
            r_head     <= INIT_POS;
            r_len      <= LEN_W'(1);
        end else begin
            r_state    <= w_next_state;
            r_idx      <= w_next_idx;
            r_ram_addr <= w_ram_addr_nx;
            r_ram_we   <= w_ram_we_nx;
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (w_next_state == S_DONE);
            if (clear) begin
                r_len  <= LEN_W'(1);
                r_head <= INIT_POS;
                r_ate  <= 1'b0;
                r_wall <= 1'b0;
                r_self <= 1'b0;
                r_win  <= 1'b0;
                r_eat  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_next_state == S_CALC) r_ate <= 1'b0;
                    S_CALC: begin
                        r_new_head <= w_step_head;
                        if (w_wall_hit) r_wall <= 1'b1;
                        else            r_eat  <= (w_step_head == apple_pos);
                    end
                    S_WR: if (w_self_hit) r_self <= 1'b1;
                    S_HEAD: begin
                        r_head <= r_new_head;
                        if (r_eat) begin
                            r_len <= w_grow_len;
                            r_ate <= 1'b1;
                        end
                        if (w_new_len == LEN_W'(MAX_LEN)) r_win <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write data follows the read port directly during the shift.
    always_comb begin
        ram_wdata = '0;
        case (r_state)
            S_INIT: ram_wdata = INIT_POS;
            S_WR:   ram_wdata = ram_rdata;
            S_HEAD: ram_wdata = r_new_head;
            default: ;
        endcase
    end

    assign ram_addr       = r_ram_addr;
    assign ram_we         = r_ram_we;
    assign busy           = r_busy;
    assign done           = r_done;
    assign ate_apple      = r_ate;
    assign wall_collision = r_wall;
    assign self_collision = r_self;
    assign win            = r_win;
    assign head_pos       = r_head;
    assign length         = r_len;

endmodule

// File: tb/tb_sga_body_shift_ctrl.sv
// Randomized and directed bench for sga_body_shift_ctrl against a queue-based snake model
// driving a behavioural single-port RAM.
module tb_sga_body_shift_ctrl;

    localparam int unsigned POS_W    = 4;
    localparam int unsigned MAX_LEN  = 16;
    localparam int unsigned LEN_W    = 5;
    localparam logic [3:0]  INIT_POS = 4'h5;

    logic             clock;
    logic             restart_n;
    logic             clear;
    logic             move_req;
    logic [1:0]       direction;
    logic [3:0]       apple_pos;
    logic [3:0]       ram_rdata;
    logic [3:0]       ram_addr;
    logic [3:0]       ram_wdata;
    logic             ram_we;
    logic             busy;
    logic             done;
    logic             ate_apple;
    logic             wall_collision;
    logic             self_collision;
    logic             win;
    logic [3:0]       head_pos;
    logic [4:0]       length;

    sga_body_shift_ctrl #(
        .POS_W(POS_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .INIT_POS(INIT_POS)
    ) dut (
        .clock(clock), .restart_n(restart_n), .clear(clear), .move_req(move_req),
        .direction(direction), .apple_pos(apple_pos), .ram_rdata(ram_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .busy(busy),
        .done(done), .ate_apple(ate_apple), .wall_collision(wall_collision),
        .self_collision(self_collision), .win(win), .head_pos(head_pos), .length(length)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural body RAM: synchronous write, registered read.
    logic [3:0] mem [16];
    int we_cnt;
    always @(posedge clock) begin
        if (!restart_n) begin
            for (int k = 0; k < 16; k++) mem[k] <= 4'h0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    // Reference model state.
    logic [3:0] m_body[$];
    logic [3:0] m_mem [16];
    bit m_wall, m_self, m_ate, m_win;
    int total, bad;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] next_pos(input logic [3:0] p, input logic [1:0] d,
                                            output bit hit);
        int x, y;
        x = int'(p) % 4;
        y = int'(p) / 4;
        hit = 1'b0;
        case (d)
            2'd0: if (x == 0) hit = 1'b1; else x--;
            2'd1: if (x == 3) hit = 1'b1; else x++;
            2'd2: if (y == 0) hit = 1'b1; else y--;
            default: if (y == 3) hit = 1'b1; else y++;
        endcase
        return 4'(y * 4 + x);
    endfunction

    task automatic model_clear();
        m_body.delete();
        m_body.push_back(INIT_POS);
        m_mem[0] = INIT_POS;
        m_wall = 0; m_self = 0; m_ate = 0; m_win = 0;
    endtask

    task automatic model_step(input logic [1:0] d, input logic [3:0] apple,
                              output int lat, output int writes);
        int L;
        bit hit, eat;
        logic [3:0] nh;
        L = m_body.size();
        nh = next_pos(m_body[0], d, hit);
        m_ate = 0;
        if (hit) begin
            m_wall = 1;
            lat = 2;
            writes = 0;
        end else begin
            eat = (nh == apple);
            for (int k = 0; k < L; k++)
                if (m_body[k] == nh && (k < L - 1 || eat)) m_self = 1;
            for (int k = L - 1; k >= 0; k--) m_mem[(k + 1) % 16] = m_body[k];
            m_mem[0] = nh;
            m_body.push_front(nh);
            if (!eat) void'(m_body.pop_back());
            m_ate = eat;
            if (m_body.size() == MAX_LEN) m_win = 1;
            lat = 2 * L + 3;
            writes = L + 1;
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".head"}, 32'(head_pos), 32'(m_body[0]));
        check_eq({tag, ".len"}, 32'(length), 32'(m_body.size()));
        check_eq({tag, ".ate"}, 32'(ate_apple), 32'(m_ate));
        check_eq({tag, ".wall"}, 32'(wall_collision), 32'(m_wall));
        check_eq({tag, ".self"}, 32'(self_collision), 32'(m_self));
        check_eq({tag, ".win"}, 32'(win), 32'(m_win));
        for (int k = 0; k < 16; k++)
            check_eq($sformatf("%s.mem%0d", tag, k), 32'(mem[k]), 32'(m_mem[k]));
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check_eq("init.we", 32'(ram_we), 32'd1);
        check_eq("init.addr", 32'(ram_addr), 32'd0);
        check_eq("init.wdata", 32'(ram_wdata), 32'(INIT_POS));
        check_eq("init.done", 32'(done), 32'd0);
        clear = 1'b0;
        model_clear();
        @(negedge clock);
        check_eq("clear.busy", 32'(busy), 32'd0);
        check_state("clear");
    endtask

    task automatic do_step(input logic [1:0] d, input logic [3:0] apple, input bit extra);
        int lat, wr, cnt, we0;
        bit seen, late_busy;
        model_step(d, apple, lat, wr);
        @(negedge clock);
        direction = d;
        apple_pos = apple;
        move_req = 1'b1;
        we0 = we_cnt;
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 100) begin
            @(negedge clock);
            cnt++;
            if (done) seen = 1;
            move_req = extra && (cnt == 2) && !seen;
        end
        move_req = 1'b0;
        check_eq("step.latency", 32'(cnt), 32'(lat));
        check_eq("step.writes", 32'(we_cnt - we0), 32'(wr));
        late_busy = 0;
        repeat (3) begin
            @(negedge clock);
            if (busy || done) late_busy = 1;
        end
        check_eq("step.no_requeue", 32'(late_busy), 32'd0);
        check_state("step");
    endtask

    task automatic try_ignored(input logic [1:0] d);
        bit act;
        act = 0;
        @(negedge clock);
        direction = d;
        move_req = 1'b1;
        @(negedge clock);
        move_req = 1'b0;
        repeat (6) begin
            if (busy || done || ram_we) act = 1;
            @(negedge clock);
        end
        check_eq("ignored.activity", 32'(act), 32'd0);
        check_state("ignored");
    endtask

    logic [1:0] win_dirs [15];

    initial begin
        bit hit;
        int steps, got_done;
        logic [1:0] d;
        logic [3:0] a;
        total = 0; bad = 0; we_cnt = 0;
        for (int k = 0; k < 16; k++) m_mem[k] = 4'h0;
        restart_n = 1'b0; clear = 1'b0; move_req = 1'b0;
        direction = 2'b00; apple_pos = 4'h0;
        repeat (3) @(negedge clock);
        check_eq("rst.head", 32'(head_pos), 32'(INIT_POS));
        check_eq("rst.len", 32'(length), 32'd1);
        check_eq("rst.flags", 32'({ate_apple, wall_collision, self_collision, win}), 32'd0);
        check_eq("rst.ctl", 32'({busy, done, ram_we}), 32'd0);
        check_eq("rst.addr", 32'(ram_addr), 32'd0);
        restart_n = 1'b1;

        // Plain step right, then walk into the right wall.
        do_clear();
        do_step(2'b01, 4'h0, 1'b0);
        do_step(2'b01, 4'h0, 1'b1);
        do_step(2'b01, 4'h0, 1'b0);
        try_ignored(2'b00);

        // Eat on the first step.
        do_clear();
        do_step(2'b01, 4'h6, 1'b0);

        // Build body {5,6,A,9}, then tail-vacate and tail-with-eat cases.
        do_clear();
        do_step(2'b11, 4'h0, 1'b0);
        do_step(2'b01, 4'hA, 1'b0);
        do_step(2'b10, 4'h6, 1'b0);
        do_step(2'b00, 4'h5, 1'b0);
        do_step(2'b10, 4'hF, 1'b0);
        do_step(2'b01, 4'hF, 1'b0);
        do_step(2'b11, 4'hF, 1'b0);
        do_step(2'b00, 4'h5, 1'b0);
        try_ignored(2'b10);

        // Clear while the shift is in its first read.
        do_clear();
        @(negedge clock);
        direction = 2'b01; apple_pos = 4'h0; move_req = 1'b1;
        @(negedge clock);
        move_req = 1'b0;
        @(negedge clock);
        check_eq("abort.busy", 32'(busy), 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check_eq("abort.we", 32'(ram_we), 32'd1);
        check_eq("abort.wdata", 32'(ram_wdata), 32'(INIT_POS));
        model_clear();
        got_done = 0;
        repeat (5) begin
            if (done) got_done++;
            @(negedge clock);
        end
        check_eq("abort.no_done", 32'(got_done), 32'd0);
        check_state("abort");

        // Hamiltonian path eating every step: grows to MAX_LEN and wins.
        win_dirs = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b11,
                     2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
        do_clear();
        for (int k = 0; k < 15; k++) begin
            a = next_pos(m_body[0], win_dirs[k], hit);
            do_step(win_dirs[k], a, k == 7);
        end
        check_eq("win.flag", 32'(win), 32'd1);
        try_ignored(2'b00);

        // Random games.
        for (int g = 0; g < 12; g++) begin
            do_clear();
            steps = 0;
            while (!(m_wall || m_self || m_win) && steps < 25) begin
                d = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) a = next_pos(m_body[0], d, hit);
                else a = 4'($urandom_range(0, 15));
                do_step(d, a, 1'($urandom_range(0, 1)));
                steps++;
            end
            if (m_wall || m_self || m_win) try_ignored(2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sga_body_shift_ctrl.md
Name: sga_body_shift_ctrl

Overview:
- Sequences the snake-body RAM for one game step: computes the new head, detects wall, self and apple hits, shifts every body segment one slot toward the tail, and writes the new head at address 0.
- Sits between the game UC, which pulses move_req once per play-time tick, and the single-port body RAM.
- Replaces the loose load_ram/counter_ram/mux_ram_addres/end_move handshake with a single req/done interface.

Parameters:
- POS_W, 4: position width; X = pos[POS_W/2-1:0], Y = pos[POS_W-1:POS_W/2] (default gives a 4x4 grid).
- MAX_LEN, 16: body length that wins the game; equals the RAM depth.
- LEN_W, 5: width of the length counter; must be able to hold MAX_LEN.
- INIT_POS, 4'h5: head position after clear.

Ports:
- clock, in, 1: system clock; all state changes on the rising edge.
- restart_n, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous game re-init; overrides every other input.
- move_req, in, 1: one-cycle request to advance the snake one step.
- direction, in, 2: step direction; 00 left (X-1), 01 right (X+1), 10 up (Y-1), 11 down (Y+1).
- apple_pos, in, POS_W: current apple position.
- ram_rdata, in, POS_W: RAM read data, valid the cycle after the address is presented.
- ram_addr, out, LEN_W-1: RAM address.
- ram_wdata, out, POS_W: RAM write data.
- ram_we, out, 1: RAM write enable.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when a step ends.
- ate_apple, out, 1: step result, apple eaten.
- wall_collision, out, 1: step result, wall hit; sticky.
- self_collision, out, 1: step result, body hit; sticky.
- win, out, 1: high when length reaches MAX_LEN; sticky.
- head_pos, out, POS_W: current head position.
- length, out, LEN_W: current body length, 1..MAX_LEN.

Behaviour:
- Reset (restart_n low, asynchronous): state IDLE; length=1; head_pos=INIT_POS; all flags, done, ram_we=0; ram_addr=0. RAM contents are undefined, so the top must assert clear before the first move.
- States: IDLE, INIT, CALC, RD, WR, HEAD, DONE.
- clear, from any state:
  - Next state INIT; length=1; head_pos=INIT_POS; all flags cleared.
  - INIT lasts 1 cycle: ram_addr=0, ram_wdata=INIT_POS, ram_we=1; then IDLE.
- IDLE:
  - A move_req is accepted only if wall_collision, self_collision and win are all 0.
  - On acceptance: ate_apple cleared, go to CALC.
  - move_req while busy or while any end flag is set is dropped; it is not queued.
- CALC, 1 cycle:
  - new_head = head_pos stepped by direction; the result is held in a register for the rest of the step.
  - Wall hit is X=0 with left, X=max with right, Y=0 with up, or Y=max with down.
  - On a wall hit: set wall_collision, go to DONE. No RAM write, head_pos and length unchanged.
  - Otherwise latch eat = (new_head == apple_pos) and set index i = length-1.
- RD / WR alternate, 2 cycles per segment:
  - RD: ram_addr=i, ram_we=0.
  - WR: ram_addr=i+1 (truncated to LEN_W-1 bits), ram_wdata=ram_rdata, ram_we=1.
  - In WR, set self_collision if ram_rdata==new_head and either i<length-1, or i==length-1 and eat=1. The tail vacates its cell unless the snake grows.
  - In WR, if i==0 go to HEAD, else decrement i and go to RD.
  - A self collision does not abort the shift; the step runs to completion.
- HEAD, 1 cycle:
  - ram_addr=0, ram_wdata=new_head, ram_we=1; head_pos<=new_head.
  - If eat: length<=length+1, ate_apple<=1.
  - If the new length equals MAX_LEN, set win.
- DONE, 1 cycle: done=1; return to IDLE.
- Result flags hold until the next accepted move_req (ate_apple) or until clear (all flags).
- Latency, with move_req sampled in IDLE at cycle 0:
  - Normal step: done at cycle 2L+3, where L is the length before the step.
  - Wall hit: done at cycle 2.
- Outputs in states other than INIT, RD, WR, HEAD: ram_we=0, ram_addr=0.
- Wrap: for L=MAX_LEN with no eat, WR targets address MAX_LEN, which truncates to 0; HEAD then overwrites it. This case is unreachable in normal play because win blocks further moves.

Test Plan:
- clear, then move_req with direction=01, INIT_POS=5, apple at 0 -> RAM[0] written 5 then 6; head_pos=6; length=1; done 5 cycles after move_req; no flags set.
- Head at X=3 (pos 7), direction=01 -> done 2 cycles after move_req; wall_collision=1; no ram_we pulses; a later move_req is ignored until clear.
- Length 1, head 5, apple_pos=6, direction=01 -> RAM[1]=5, RAM[0]=6; length=2; ate_apple=1.
- Body {0:5, 1:6, 2:A, 3:9} (length 4), direction=10, apple elsewhere -> new head 1, no hit; then force a move into cell 6 -> self_collision=1, shift still completes, done asserted.
- clear asserted during RD -> next cycle INIT writes RAM[0]=INIT_POS; length=1; flags 0; done not pulsed.
- Preload length=15 and place apple at new_head -> length=16, win=1; a further move_req is ignored; move_req while busy mid-step is dropped.
